crash_detect: RTL and testbench

- Pixel-level collision detector, directly upstream of the enemy sprite blocks.
- Watches the per-pixel alpha outputs of the enemy, bullet and player layers during the VGA scan.
- Counts the overlapping pixels for each enemy slot in each frame.
- Emits at most one bullet-hit pulse and one player-crash pulse per enemy per frame. The enemy life/state FSMs consume these pulses.

---
 rtl/crash_detect_pkg.sv | 17 +
 rtl/crash_slot.sv | 65 ++++++
 rtl/crash_detect.sv | 119 +++++++++++
 tb/tb_crash_detect.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/crash_detect_pkg.sv
// Shared constants and FSM encoding for the pixel-level collision detector.
// Thresholds and enemy count are reused by the enemy sprite blocks downstream.
package crash_detect_pkg;

  localparam int ENEMY_NUM         = 4;
  localparam int ENEMY_NUM_BIT_LEN = 2;
  localparam int CRASH_HIT_MIN_PIX = 4;
  localparam int CRASH_ME_MIN_PIX  = 8;
  localparam int CRASH_CNT_W       = 4;

  typedef enum logic [1:0] {
    CRASH_IDLE = 2'd0,
    CRASH_WAIT = 2'd1,
    CRASH_SCAN = 2'd2
  } crash_state_e;

endpackage

// File: rtl/crash_slot.sv
// One enemy slot: saturating bullet/player overlap counters and per-frame
// reported flags; raises a declare strobe in the cycle a threshold is reached.
module crash_slot
  import crash_detect_pkg::*;
#(
  parameter int HIT_MIN_PIX   = CRASH_HIT_MIN_PIX,
  parameter int CRASH_MIN_PIX = CRASH_ME_MIN_PIX,
  parameter int CNT_W         = CRASH_CNT_W
) (
  input  logic clk_vga,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_hit_inc,
  input  logic i_crash_inc,
  output logic o_hit_declare,
  output logic o_crash_declare
);

  localparam logic [CNT_W-1:0] HIT_SAT   = CNT_W'(HIT_MIN_PIX);
  localparam logic [CNT_W-1:0] CRASH_SAT = CNT_W'(CRASH_MIN_PIX);

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_crash_cnt;
  logic             r_hit_rep;
  logic             r_crash_rep;
  logic [CNT_W-1:0] w_hit_next;
  logic [CNT_W-1:0] w_crash_next;
  logic             w_hit_reach;
  logic             w_crash_reach;

  // A player crash outranks a bullet hit reached on the same pixel.
  always_comb begin
    w_hit_next   = r_hit_cnt;
    w_crash_next = r_crash_cnt;
    if (i_hit_inc && (r_hit_cnt != HIT_SAT))
      w_hit_next = r_hit_cnt + 1'b1;
    if (i_crash_inc && (r_crash_cnt != CRASH_SAT))
      w_crash_next = r_crash_cnt + 1'b1;
    w_hit_reach     = i_hit_inc && (w_hit_next == HIT_SAT);
    w_crash_reach   = i_crash_inc && (w_crash_next == CRASH_SAT);
    o_crash_declare = !i_clear && w_crash_reach && !r_crash_rep;
    o_hit_declare   = !i_clear && w_hit_reach && !r_hit_rep && !r_crash_rep
                      && !o_crash_declare;
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt   <= '0;
      r_crash_cnt <= '0;
      r_hit_rep   <= 1'b0;
      r_crash_rep <= 1'b0;
    end else if (i_clear) begin
      r_hit_cnt   <= '0;
      r_crash_cnt <= '0;
      r_hit_rep   <= 1'b0;
      r_crash_rep <= 1'b0;
    end else begin
      r_hit_cnt   <= w_hit_next;
      r_crash_cnt <= w_crash_next;
      r_hit_rep   <= r_hit_rep | w_hit_reach;
      r_crash_rep <= r_crash_rep | w_crash_reach;
    end
  end

endmodule

// File: rtl/crash_detect.sv
// Pixel-level collision detector: counts enemy/bullet and enemy/player overlaps
// per slot per frame and emits at most one hit and one crash pulse per enemy.
module crash_detect
  import crash_detect_pkg::*;
#(
  parameter int ENEMY_NUM     = crash_detect_pkg::ENEMY_NUM,
  parameter int ENEMY_IDX_W   = ENEMY_NUM_BIT_LEN,
  parameter int HIT_MIN_PIX   = CRASH_HIT_MIN_PIX,
  parameter int CRASH_MIN_PIX = CRASH_ME_MIN_PIX,
  parameter int CNT_W         = CRASH_CNT_W
) (
  input  logic                   clk_vga,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   v_sync_i,
  input  logic                   enemy_alpha_i,
  input  logic [ENEMY_IDX_W-1:0] enemy_idx_i,
  input  logic                   bullet_alpha_i,
  input  logic                   me_alpha_i,
  output logic                   crash_enemy_bullet_o,
  output logic                   crash_me_enemy_o,
  output logic [ENEMY_IDX_W-1:0] crash_idx_o,
  output logic                   bullet_consume_o
);

  crash_state_e r_state;
  logic         r_vsync_q;

  logic                   w_frame_start;
  logic                   w_clear;
  logic                   w_pix_valid;
  logic [ENEMY_NUM-1:0]   w_hit_inc;
  logic [ENEMY_NUM-1:0]   w_crash_inc;
  logic [ENEMY_NUM-1:0]   w_hit_decl;
  logic [ENEMY_NUM-1:0]   w_crash_decl;
  logic                   w_hit_any;
  logic                   w_crash_any;
  logic [ENEMY_IDX_W-1:0] w_hit_idx;
  logic [ENEMY_IDX_W-1:0] w_crash_idx;

  // Counting is suppressed outside SCAN and on the frame-boundary pixel itself.
  assign w_frame_start = v_sync_i & ~r_vsync_q;
  assign w_clear       = !en_i || (r_state != CRASH_SCAN) || w_frame_start;
  assign w_pix_valid   = !w_clear && enemy_alpha_i;

  for (genvar k = 0; k < ENEMY_NUM; k++) begin : g_slot
    assign w_hit_inc[k]   = w_pix_valid && bullet_alpha_i
                            && (enemy_idx_i == ENEMY_IDX_W'(k));
    assign w_crash_inc[k] = w_pix_valid && me_alpha_i
                            && (enemy_idx_i == ENEMY_IDX_W'(k));

    crash_slot #(
      .HIT_MIN_PIX  (HIT_MIN_PIX),
      .CRASH_MIN_PIX(CRASH_MIN_PIX),
      .CNT_W        (CNT_W)
    ) u_slot (
      .clk_vga        (clk_vga),
      .rst_n          (rst_n),
      .i_clear        (w_clear),
      .i_hit_inc      (w_hit_inc[k]),
      .i_crash_inc    (w_crash_inc[k]),
      .o_hit_declare  (w_hit_decl[k]),
      .o_crash_declare(w_crash_decl[k])
    );
  end

  always_comb begin
    w_hit_any   = 1'b0;
    w_crash_any = 1'b0;
    w_hit_idx   = '0;
    w_crash_idx = '0;
    for (int k = 0; k < ENEMY_NUM; k++) begin
      if (w_hit_decl[k]) begin
        w_hit_any = 1'b1;
        w_hit_idx = ENEMY_IDX_W'(k);
      end
      if (w_crash_decl[k]) begin
        w_crash_any = 1'b1;
        w_crash_idx = ENEMY_IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= CRASH_IDLE;
      r_vsync_q            <= 1'b0;
      crash_enemy_bullet_o <= 1'b0;
      crash_me_enemy_o     <= 1'b0;
      bullet_consume_o     <= 1'b0;
      crash_idx_o          <= '0;
    end else begin
      r_vsync_q            <= v_sync_i;
      crash_enemy_bullet_o <= 1'b0;
      crash_me_enemy_o     <= 1'b0;
      bullet_consume_o     <= 1'b0;
      if (!en_i) begin
        r_state <= CRASH_IDLE;
      end else begin
        case (r_state)
          CRASH_IDLE: r_state <= CRASH_WAIT;
          CRASH_WAIT: if (w_frame_start) r_state <= CRASH_SCAN;
          CRASH_SCAN: begin
            if (w_crash_any) begin
              crash_me_enemy_o <= 1'b1;
              crash_idx_o      <= w_crash_idx;
            end else if (w_hit_any) begin
              crash_enemy_bullet_o <= 1'b1;
              bullet_consume_o     <= 1'b1;
              crash_idx_o          <= w_hit_idx;
            end
          end
          default: r_state <= CRASH_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crash_detect.sv
// Directed bench for crash_detect: a default instance plus one with equal
// hit/crash thresholds to exercise the same-pixel priority rule.
module tb_crash_detect;

  logic       clk_vga = 1'b0;
  logic       rst_n;
  logic       en_i;
  logic       v_sync_i;
  logic       enemy_alpha_i;
  logic [1:0] enemy_idx_i;
  logic       bullet_alpha_i;
  logic       me_alpha_i;

  logic       bullet_o, me_o, consume_o;
  logic [1:0] idx_o;
  logic       bullet2_o, me2_o, consume2_o;
  logic [1:0] idx2_o;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] expIdx = 2'd0;
  logic [1:0] expIdx2 = 2'd0;

  always #5 clk_vga = ~clk_vga;

  crash_detect dut (
    .clk_vga             (clk_vga),
    .rst_n               (rst_n),
    .en_i                (en_i),
    .v_sync_i            (v_sync_i),
    .enemy_alpha_i       (enemy_alpha_i),
    .enemy_idx_i         (enemy_idx_i),
    .bullet_alpha_i      (bullet_alpha_i),
    .me_alpha_i          (me_alpha_i),
    .crash_enemy_bullet_o(bullet_o),
    .crash_me_enemy_o    (me_o),
    .crash_idx_o         (idx_o),
    .bullet_consume_o    (consume_o)
  );

  crash_detect #(.HIT_MIN_PIX(4), .CRASH_MIN_PIX(4)) dutEq (
    .clk_vga             (clk_vga),
    .rst_n               (rst_n),
    .en_i                (en_i),
    .v_sync_i            (v_sync_i),
    .enemy_alpha_i       (enemy_alpha_i),
    .enemy_idx_i         (enemy_idx_i),
    .bullet_alpha_i      (bullet_alpha_i),
    .me_alpha_i          (me_alpha_i),
    .crash_enemy_bullet_o(bullet2_o),
    .crash_me_enemy_o    (me2_o),
    .crash_idx_o         (idx2_o),
    .bullet_consume_o    (consume2_o)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic applyStimulus(input logic ea, input logic [1:0] idx,
                               input logic ba, input logic ma, input logic vs);
    enemy_alpha_i  = ea;
    enemy_idx_i    = idx;
    bullet_alpha_i = ba;
    me_alpha_i     = ma;
    v_sync_i       = vs;
    @(posedge clk_vga);
    #1;
  endtask

  task automatic checkVec(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed {hit,crash,consume,idx}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic b, input logic m, input logic [1:0] idx);
    checkVec(tag, {bullet_o, me_o, consume_o, idx_o}, {b, m, b, idx});
  endtask

  task automatic checkOutputEq(input string tag, input logic b, input logic m, input logic [1:0] idx);
    checkVec(tag, {bullet2_o, me2_o, consume2_o, idx2_o}, {b, m, b, idx});
  endtask

  task automatic frameStart();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("frame_start", 1'b0, 1'b0, expIdx);
  endtask

  // Runs n overlap pixels on one slot; hitAt/crashAt give the pixel (1-based)
  // whose edge must produce the pulse, 0 meaning no pulse expected.
  task automatic runPixels(input string tag, input int n, input logic [1:0] idx,
                           input logic ba, input logic ma, input int hitAt, input int crashAt);
    logic b, m;
    for (int i = 1; i <= n; i++) begin
      applyStimulus(1'b1, idx, ba, ma, 1'b0);
      b = (i == hitAt);
      m = (i == crashAt);
      if (b || m) expIdx = idx;
      checkOutput(tag, b, m, expIdx);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en_i  = 1'b0;
    enemy_alpha_i = 1'b0; enemy_idx_i = 2'd0;
    bullet_alpha_i = 1'b0; me_alpha_i = 1'b0; v_sync_i = 1'b0;
    repeat (2) @(posedge clk_vga);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 2'd0);
    checkOutputEq("reset_eq", 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;

    $display("[TB] idle with en_i low");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 2'd2, 1'b1, 1'b1, (i % 20) == 10);
      checkOutput("idle", 1'b0, 1'b0, 2'd0);
    end

    $display("[TB] partial first frame");
    en_i = 1'b1;
    runPixels("partial", 10, 2'd2, 1'b1, 1'b0, 0, 0);
    frameStart();
    runPixels("first_hit", 4, 2'd2, 1'b1, 1'b0, 4, 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("first_hit_end", 1'b0, 1'b0, 2'd2);

    $display("[TB] once per frame");
    frameStart();
    runPixels("once_a", 50, 2'd1, 1'b1, 1'b0, 4, 0);
    frameStart();
    runPixels("once_b", 50, 2'd1, 1'b1, 1'b0, 4, 0);

    $display("[TB] hit versus crash priority");
    expIdx2 = 2'd1;
    frameStart();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
      if (i == 4 || i == 8) expIdx = 2'd3;
      if (i == 4) expIdx2 = 2'd3;
      checkOutput("prio", i == 4, i == 8, expIdx);
      checkOutputEq("prio_eq", 1'b0, i == 4, expIdx2);
    end

    $display("[TB] threshold on frame boundary");
    frameStart();
    runPixels("bnd_pre", 3, 2'd2, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    checkOutput("bnd_edge", 1'b0, 1'b0, expIdx);
    runPixels("bnd_post", 4, 2'd2, 1'b1, 1'b0, 4, 0);

    $display("[TB] mid-frame reset");
    frameStart();
    runPixels("rst_pre", 3, 2'd1, 1'b1, 1'b0, 0, 0);
    rst_n = 1'b0;
    #3;
    expIdx = 2'd0;
    checkOutput("rst_mid", 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    runPixels("rst_post", 2, 2'd1, 1'b1, 1'b0, 0, 0);
    frameStart();
    runPixels("rst_frame", 4, 2'd1, 1'b1, 1'b0, 4, 0);

    $display("[TB] enable drop");
    frameStart();
    runPixels("en_pre", 3, 2'd3, 1'b1, 1'b0, 0, 0);
    en_i = 1'b0;
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("en_drop", 1'b0, 1'b0, expIdx);
    en_i = 1'b1;
    runPixels("en_post", 2, 2'd3, 1'b1, 1'b0, 0, 0);
    frameStart();
    runPixels("en_frame", 4, 2'd3, 1'b1, 1'b0, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
